// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: round-robin grant plus a one-entry access stage
// that drives the asynchronous-read data memory one cycle after acceptance.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_w,
    output logic              mem_r,
    input  logic [DATA_W-1:0] mem_dout
);

    logic              prio_q,  prio_d;
    logic              valid_q, valid_d;
    logic              owner_q, owner_d;
    logic              we_q,    we_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // Grant: sole requester wins; under contention the priority pointer decides.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0 && (!req1 || !prio_q)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Next state: load the stage on acceptance, hand priority to the other side.
    always_comb begin
        prio_d  = prio_q;
        valid_d = gnt0 | gnt1;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (gnt0) begin
            prio_d  = 1'b1;
            owner_d = 1'b0;
            we_d    = we0;
            addr_d  = addr0;
            wdata_d = wdata0;
        end else if (gnt1) begin
            prio_d  = 1'b0;
            owner_d = 1'b1;
            we_d    = we1;
            addr_d  = addr1;
            wdata_d = wdata1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q  <= 1'b0;
            valid_q <= 1'b0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            prio_q  <= prio_d;
            valid_q <= valid_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Stage outputs are gated by valid so an empty or reset stage drives all zeros.
    always_comb begin
        mem_adr = '0;
        mem_din = '0;
        mem_w   = 1'b0;
        mem_r   = 1'b0;
        ack0    = 1'b0;
        ack1    = 1'b0;
        rdata0  = '0;
        rdata1  = '0;
        if (valid_q) begin
            mem_adr = addr_q;
            mem_din = wdata_q;
            mem_w   = we_q;
            mem_r   = ~we_q;
            ack0    = ~owner_q;
            ack1    = owner_q;
            if (!we_q && !owner_q) begin
                rdata0 = mem_dout;
            end
            if (!we_q && owner_q) begin
                rdata1 = mem_dout;
            end
        end
    end

endmodule
